// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the BCD stopwatch.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'h40;

  // Index 0 is the least significant entry; codes 10..15 are blanked.
  localparam logic [15:0][6:0] SEG_TABLE = {
    SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, SEG_ZERO
  };

endpackage

// File: rtl/stopwatch_bcd_seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder.
module seg7_decoder
  import stopwatch_pkg::*;
(
  input  bcd_t       bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[bcd_i];

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by a one-cycle tick enable, with four
// active-low seven-segment outputs. Optional lap-hold display is built
// when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59,
  parameter int WRAP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_EN
  input  logic       lap,
`endif
  output bcd_t       sec_ones,
  output bcd_t       sec_tens,
  output bcd_t       min_ones,
  output bcd_t       min_tens,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic       running,
  output logic       rollover
);

  localparam bcd_t MAX_T = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MAX_O = bcd_t'(MAX_MIN % 10);

  sw_state_t   state_q;
  bcd_t        so_q, st_q, mo_q, mt_q;
  logic        ss_hist_q, clr_hist_q, armed_q;
  logic        running_q, rollover_q;
  logic        ss_ev, clr_ev, at_term;
  logic [15:0] live, shown;

  // Buttons already high when reset releases must be released and pressed
  // again, so events are masked for the first cycle after reset while the
  // history registers catch up with the inputs.
  assign ss_ev   = armed_q & start_stop & ~ss_hist_q;
  assign clr_ev  = armed_q & clear & ~clr_hist_q;
  assign at_term = (mt_q == MAX_T) && (mo_q == MAX_O) &&
                   (st_q == 4'd5) && (so_q == 4'd9);
  assign live    = {mt_q, mo_q, st_q, so_q};

  // Control FSM and BCD counter; priority clear > start_stop > tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      so_q       <= '0;
      st_q       <= '0;
      mo_q       <= '0;
      mt_q       <= '0;
      ss_hist_q  <= 1'b0;
      clr_hist_q <= 1'b0;
      armed_q    <= 1'b0;
      running_q  <= 1'b0;
      rollover_q <= 1'b0;
    end else begin
      ss_hist_q  <= start_stop;
      clr_hist_q <= clear;
      armed_q    <= 1'b1;
      rollover_q <= 1'b0;
      if (clr_ev) begin
        state_q   <= IDLE;
        running_q <= 1'b0;
        so_q      <= '0;
        st_q      <= '0;
        mo_q      <= '0;
        mt_q      <= '0;
      end else if (ss_ev) begin
        // A tick in the same cycle is dropped in both directions.
        if (state_q == RUN) begin
          state_q   <= PAUSE;
          running_q <= 1'b0;
        end else begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
      end else if (tick && state_q == RUN) begin
        if (at_term) begin
          if (WRAP != 0) begin
            so_q       <= '0;
            st_q       <= '0;
            mo_q       <= '0;
            mt_q       <= '0;
            rollover_q <= 1'b1;
          end else begin
            // Saturated: hold the count; a restart only pauses again.
            state_q   <= PAUSE;
            running_q <= 1'b0;
          end
        end else if (so_q != 4'd9) begin
          so_q <= so_q + 4'd1;
        end else begin
          so_q <= '0;
          if (st_q != 4'd5) begin
            st_q <= st_q + 4'd1;
          end else begin
            st_q <= '0;
            if (mo_q != 4'd9) begin
              mo_q <= mo_q + 4'd1;
            end else begin
              mo_q <= '0;
              mt_q <= mt_q + 4'd1;
            end
          end
        end
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        lap_hist_q, lap_hold_q, lap_ev;
  logic [15:0] held_q;

  assign lap_ev = armed_q & lap & ~lap_hist_q;

  // Lap hold: first lap in RUN freezes the display, next lap releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_hist_q <= 1'b0;
      lap_hold_q <= 1'b0;
      held_q     <= '0;
    end else begin
      lap_hist_q <= lap;
      if (clr_ev) begin
        lap_hold_q <= 1'b0;
      end else if (lap_ev) begin
        if (lap_hold_q) begin
          lap_hold_q <= 1'b0;
        end else if (state_q == RUN) begin
          lap_hold_q <= 1'b1;
          held_q     <= live;
        end
      end
    end
  end

  assign shown = lap_hold_q ? held_q : live;
`else
  assign shown = live;
`endif

  assign {min_tens, min_ones, sec_tens, sec_ones} = shown;
  assign running  = running_q;
  assign rollover = rollover_q;

  seg7_decoder u_hex0 (.bcd_i(shown[3:0]),   .seg_o(hex0));
  seg7_decoder u_hex1 (.bcd_i(shown[7:4]),   .seg_o(hex1));
  seg7_decoder u_hex2 (.bcd_i(shown[11:8]),  .seg_o(hex2));
  seg7_decoder u_hex3 (.bcd_i(shown[15:12]), .seg_o(hex3));

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed self-checking bench for stopwatch_bcd: a default instance
// (59 min, wrap) plus two MAX_MIN=2 instances, one wrapping, one saturating.
module tb_stopwatch_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] tk  = '0;
  logic [2:0] ss  = '0;
  logic [2:0] cl  = '0;
`ifdef STOPWATCH_LAP_EN
  logic [2:0] lp  = '0;
`endif

  logic [3:0] so [3];
  logic [3:0] st [3];
  logic [3:0] mo [3];
  logic [3:0] mt [3];
  logic [6:0] h0 [3];
  logic [6:0] h1 [3];
  logic [6:0] h2 [3];
  logic [6:0] h3 [3];
  logic [2:0] run;
  logic [2:0] rov;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_bcd u_dut (
    .clk(clk), .rst(rst), .tick(tk[0]), .start_stop(ss[0]), .clear(cl[0]),
`ifdef STOPWATCH_LAP_EN
    .lap(lp[0]),
`endif
    .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
    .hex0(h0[0]), .hex1(h1[0]), .hex2(h2[0]), .hex3(h3[0]),
    .running(run[0]), .rollover(rov[0])
  );

  stopwatch_bcd #(.MAX_MIN(2), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .tick(tk[1]), .start_stop(ss[1]), .clear(cl[1]),
`ifdef STOPWATCH_LAP_EN
    .lap(lp[1]),
`endif
    .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
    .hex0(h0[1]), .hex1(h1[1]), .hex2(h2[1]), .hex3(h3[1]),
    .running(run[1]), .rollover(rov[1])
  );

  stopwatch_bcd #(.MAX_MIN(2), .WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .tick(tk[2]), .start_stop(ss[2]), .clear(cl[2]),
`ifdef STOPWATCH_LAP_EN
    .lap(lp[2]),
`endif
    .sec_ones(so[2]), .sec_tens(st[2]), .min_ones(mo[2]), .min_tens(mt[2]),
    .hex0(h0[2]), .hex1(h1[2]), .hex2(h2[2]), .hex3(h3[2]),
    .running(run[2]), .rollover(rov[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mmss(input int d);
    return {mt[d], mo[d], st[d], so[d]};
  endfunction

  function automatic logic [27:0] hexes(input int d);
    return {h3[d], h2[d], h1[d], h0[d]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int d);
    ss[d] = 1'b1;
    cyc();
    ss[d] = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int d, input int n);
    tk[d] = 1'b1;
    repeat (n) cyc();
    tk[d] = 1'b0;
  endtask

  initial begin
    // Reset
    cyc();
    cyc();
    chk("rst_digits", 32'(mmss(0)), 32'h0000);
    chk("rst_running", 32'(run[0]), 32'd0);
    chk("rst_rollover", 32'(rov[0]), 32'd0);
    chk("rst_hex", 32'(hexes(0)), 32'h810_2040);
    rst = 1'b0;
    cyc();

    // Start, then 75 ticks spaced 5 clocks apart
    press(0);
    chk("start_running", 32'(run[0]), 32'd1);
    for (int i = 0; i < 75; i++) begin
      tk[0] = 1'b1;
      cyc();
      tk[0] = 1'b0;
      if (i == 0)  chk("first_tick_latency", 32'(mmss(0)), 32'h0001);
      if (i == 58) chk("at_00_59", 32'(mmss(0)), 32'h0059);
      if (i == 59) chk("carry_01_00", 32'(mmss(0)), 32'h0100);
      repeat (4) cyc();
    end
    chk("count_01_15", 32'(mmss(0)), 32'h0115);
    chk("running_01_15", 32'(run[0]), 32'd1);

    // 09:59 -> 10:00
    ticks(0, 524);
    chk("at_09_59", 32'(mmss(0)), 32'h0959);
    ticks(0, 1);
    chk("carry_10_00", 32'(mmss(0)), 32'h1000);
    chk("hex_10_00", 32'(hexes(0)), {7'h79, 7'h40, 7'h40, 7'h40});

    // Clear, then start coincident with tick from IDLE
    cl[0] = 1'b1;
    cyc();
    cl[0] = 1'b0;
    cyc();
    chk("clear_digits", 32'(mmss(0)), 32'h0000);
    chk("clear_idle", 32'(run[0]), 32'd0);
    ss[0] = 1'b1;
    tk[0] = 1'b1;
    cyc();
    ss[0] = 1'b0;
    tk[0] = 1'b0;
    chk("start_tick_run", 32'(run[0]), 32'd1);
    chk("start_tick_nocount", 32'(mmss(0)), 32'h0000);
    cyc();

    // clear + start_stop together in RUN at 03:12
    ticks(0, 192);
    chk("at_03_12", 32'(mmss(0)), 32'h0312);
    cl[0] = 1'b1;
    ss[0] = 1'b1;
    cyc();
    cl[0] = 1'b0;
    ss[0] = 1'b0;
    chk("clr_ss_digits", 32'(mmss(0)), 32'h0000);
    chk("clr_ss_idle", 32'(run[0]), 32'd0);
    ticks(0, 1);
    chk("idle_no_count", 32'(mmss(0)), 32'h0000);

    // Reset mid-count at 05:30 with a tick, start_stop held across it
    press(0);
    ticks(0, 330);
    chk("at_05_30", 32'(mmss(0)), 32'h0530);
    rst   = 1'b1;
    tk[0] = 1'b1;
    ss[0] = 1'b1;
    cyc();
    tk[0] = 1'b0;
    chk("midrst_digits", 32'(mmss(0)), 32'h0000);
    chk("midrst_running", 32'(run[0]), 32'd0);
    chk("midrst_hex", 32'(hexes(0)), {4{7'h40}});
    rst = 1'b0;
    repeat (3) cyc();
    chk("held_ss_no_start", 32'(run[0]), 32'd0);
    ticks(0, 3);
    chk("held_ss_no_count", 32'(mmss(0)), 32'h0000);
    ss[0] = 1'b0;
    cyc();
    ss[0] = 1'b1;
    cyc();
    ss[0] = 1'b0;
    chk("repress_start", 32'(run[0]), 32'd1);

    // MAX_MIN=2 wrap
    press(1);
    ticks(1, 179);
    chk("wrap_at_02_59", 32'(mmss(1)), 32'h0259);
    tk[1] = 1'b1;
    cyc();
    tk[1] = 1'b0;
    chk("wrap_to_zero", 32'(mmss(1)), 32'h0000);
    chk("wrap_rollover", 32'(rov[1]), 32'd1);
    chk("wrap_running", 32'(run[1]), 32'd1);
    cyc();
    chk("wrap_rollover_1cyc", 32'(rov[1]), 32'd0);
    ticks(1, 1);
    chk("wrap_counts_on", 32'(mmss(1)), 32'h0001);

    // MAX_MIN=2 saturate
    press(2);
    ticks(2, 179);
    chk("sat_at_02_59", 32'(mmss(2)), 32'h0259);
    chk("sat_running_before", 32'(run[2]), 32'd1);
    tk[2] = 1'b1;
    cyc();
    tk[2] = 1'b0;
    chk("sat_hold", 32'(mmss(2)), 32'h0259);
    chk("sat_running_drop", 32'(run[2]), 32'd0);
    chk("sat_no_rollover", 32'(rov[2]), 32'd0);
    ticks(2, 5);
    chk("sat_more_ticks", 32'(mmss(2)), 32'h0259);
    press(2);
    chk("sat_restart_run", 32'(run[2]), 32'd1);
    ticks(2, 1);
    chk("sat_restart_hold", 32'(mmss(2)), 32'h0259);

`ifdef STOPWATCH_LAP_EN
    // Lap hold
    cl[0] = 1'b1;
    cyc();
    cl[0] = 1'b0;
    cyc();
    press(0);
    ticks(0, 10);
    lp[0] = 1'b1;
    cyc();
    lp[0] = 1'b0;
    chk("lap_capture", 32'(mmss(0)), 32'h0010);
    ticks(0, 5);
    chk("lap_held", 32'(mmss(0)), 32'h0010);
    chk("lap_held_hex", 32'(hexes(0)), {7'h40, 7'h40, 7'h79, 7'h40});
    lp[0] = 1'b1;
    cyc();
    lp[0] = 1'b0;
    chk("lap_release", 32'(mmss(0)), 32'h0015);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_bcd.md
Name: stopwatch_bcd

Overview:
- MM:SS stopwatch that consumes the one-cycle tick pulse from the board's clock-division stage (nominally 1 Hz from the 50 MHz board clock) and counts in BCD.
- Drives four active-low seven-segment digits and status flags.
- Sits between the tick generator and the HEX display pins; all logic runs on clk, and tick is used as an enable, never as a clock.

Parameters:
- MAX_MIN, 59: highest minute value, 1..99; the count spans 00:00 to MAX_MIN:59.
- WRAP, 1: 1 means wrap to 00:00 after MAX_MIN:59; 0 means saturate and stop.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-clk-wide count-enable pulse.
- start_stop  input  1  level button, already synchronised, active-high; acts on its rising edge.
- clear  input  1  level button, already synchronised, active-high; acts on its rising edge.
- sec_ones  output  4  BCD seconds units.
- sec_tens  output  4  BCD seconds tens, 0..5.
- min_ones  output  4  BCD minutes units.
- min_tens  output  4  BCD minutes tens.
- hex0..hex3  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 = sec_ones … hex3 = min_tens.
- running  output  1  high in RUN.
- rollover  output  1  one-cycle pulse when the count wraps from MAX_MIN:59 to 00:00.
- lap  input  1  present only with the optional feature.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - rst high at a clk edge sets the state to IDLE and all digits to 0.
  - running = 0, rollover = 0, hex0..hex3 = 7'b1000000 (shows "0").
  - The edge-detect history registers are set to 0.
  - rst mid-count aborts immediately; no partial update is kept.
- Edge detection: one history register per button; event = input & ~history, evaluated each clk.
- FSM:
  - IDLE: the count holds; a start_stop event moves to RUN.
  - RUN: counts on tick; a start_stop event moves to PAUSE.
  - PAUSE: the count holds; a start_stop event moves to RUN.
  - A clear event in any state zeroes the digits and moves to IDLE.
  - Saturation with WRAP = 0 moves to PAUSE.
- Priority in one cycle: rst > clear > start_stop > tick.
  - A tick coincident with a start_stop event is ignored in both directions: a start does not count that tick, and a stop does not count it either.
  - Counting happens only when the registered state is RUN and no higher-priority event is present.
- Increment, one clk after the tick is sampled (registered digits):
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into minutes.
  - min_ones 9 -> 0 carries into min_tens.
- Terminal value: MAX_MIN:59, with the minute comparison done on the combined BCD digits.
  - WRAP = 1: the next tick gives 00:00, rollover = 1 for exactly that cycle, and the state stays RUN.
  - WRAP = 0: the count holds at MAX_MIN:59, state goes to PAUSE, and running drops in the same cycle as the blocked tick. A start_stop event from PAUSE at terminal returns to RUN, but ticks are ignored there; only clear restarts the count.
- Digits never take non-BCD values; sec_tens never exceeds 5.
- hex outputs are combinational decodes of the digit registers, so they have zero additional latency relative to the digits.
- running is registered and equals (state == RUN).

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds the lap input with rising-edge detection.
  - A lap event in RUN captures the current digits into a display-hold register and sets lap_hold; the count continues internally.
  - While lap_hold is set, hex0..hex3 and the BCD outputs show the held value.
  - A second lap event, any clear, or rst releases the hold.
  - A lap event in IDLE or PAUSE is ignored.
  - clear has priority over lap.
- Undefined: no lap port and no hold register; the outputs always show the live count.

Decomposition:
- Package stopwatch_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;
  - typedef logic [3:0] bcd_t;
  - constants SEG_BLANK = 7'h7F and SEG_ZERO = 7'h40;
  - the 16-entry segment pattern table (values 10..15 decode to blank).
- Sub-module seg7_decoder: bcd_t in, 7-bit active-low out, purely combinational; instantiated four times.

Test Plan:
- rst, then a start_stop pulse, then 75 ticks spaced 5 clk apart -> digits read 01:15, running = 1; each digit updates one clk after its tick.
- Count at 00:59 plus one tick -> 01:00; a second sequence from 09:59 plus one tick -> 10:00; hex3 = 7'b1111001 ("1").
- MAX_MIN = 2, WRAP = 1, at 02:59 plus one tick -> 00:00, with rollover high for exactly 1 cycle. With WRAP = 0: holds at 02:59, running -> 0, and further ticks cause no change.
- start_stop event and tick in the same cycle from IDLE -> state RUN, count stays 00:00. clear and start_stop in the same cycle while in RUN at 03:12 -> 00:00, IDLE.
- rst asserted mid-count at 05:30 with a simultaneous tick -> next cycle shows 00:00, IDLE, all hex = 7'b1000000; start_stop held high over reset and after it -> no start until it is released and pressed again.
- With STOPWATCH_LAP_EN: lap at 00:10, then 5 ticks -> display shows 00:10 while the internal count is 00:15; a second lap -> display shows 00:15.
